embedded_computer_system_pio_arbiter: RTL and testbench
=======================================================

EMBEDDED_COMPUTER_SYSTEM_PIO_ARBITER -- requirements
Module: embedded_computer_system_pio_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, number of requesters (2..4).
REQ-002 The block SHALL have parameter DATA_W, default 8, PIO output width.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 4, idle gap after each PIO write (0..255).
REQ-004 The block SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req  input  NUM_REQ  per-requester write request, level, held until ack.
REQ-007 The block SHALL have port wdata  input  NUM_REQ*DATA_W  per-requester data, requester i in bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port ack  output  NUM_REQ  one-cycle grant/done pulse per requester.
REQ-009 The block SHALL have port pio_address  output  2  Avalon address to PIO slave, always 0.
REQ-010 The block SHALL have port pio_chipselect  output  1  Avalon chipselect.
REQ-011 The block SHALL have port pio_write_n  output  1  Avalon write strobe, active-low.
REQ-012 The block SHALL have port pio_writedata  output  32  Avalon write data, bits above DATA_W zero.
REQ-013 The block SHALL have port pio_readdata  input  32  Avalon read data, zero-wait-state, combinational from PIO register.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port grant_id  output  2  index of last granted requester.
REQ-016 The block SHALL have ports mismatch_clr  input  1  and mismatch  output  1  sticky readback error flag and its clear.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ (readback build only), GAP.
REQ-018 In IDLE with any req bit high, the block SHALL select one requester, register its wdata, and enter WRITE on the next edge; no req -> stay IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at grant_id+1 modulo NUM_REQ; after reset search starts at index 0.
REQ-020 WRITE SHALL last exactly one cycle: pio_chipselect=1, pio_write_n=0, pio_writedata={zeros, registered data}, ack[grant_id]=1.
REQ-021 Latency: req sampled high in IDLE at edge t -> write strobe and ack during cycle t+1.
REQ-022 req and wdata SHALL be sampled only in IDLE; a req deasserted before sampling produces no write and no ack.
REQ-023 After WRITE (or READ), GAP SHALL last HOLD_CYCLES cycles via a down-counter, then IDLE; HOLD_CYCLES=0 skips GAP.
REQ-024 Outside WRITE/READ, pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-025 Requests arriving during WRITE/READ/GAP SHALL wait; no request is lost or reordered beyond round-robin order.
REQ-026 mismatch_clr SHALL clear mismatch next edge; simultaneous set and clear SHALL leave mismatch set.

Reset
REQ-027 While reset_n=0: state=IDLE, ack=0, busy=0, grant_id=NUM_REQ-1 (so search begins at 0), mismatch=0, counter=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-028 Reset mid-transaction SHALL abort immediately with no ack issued after reset assertion.

Configuration
REQ-029 With macro PIO_ARB_READBACK_EN defined, WRITE SHALL be followed by one READ cycle (pio_chipselect=1, pio_write_n=1), pio_readdata[DATA_W-1:0] compared to registered data, inequality setting mismatch at the end of READ.
REQ-030 Without PIO_ARB_READBACK_EN, READ SHALL not exist, WRITE goes to GAP/IDLE, mismatch SHALL be tied 0, mismatch_clr ignored.

Verification
REQ-031 Single req[1]=1, wdata[15:8]=8'hA5 -> one write cycle with pio_writedata=32'h000000A5, ack[1] pulse same cycle, grant_id=1.
REQ-032 req=3'b111 held, data 8'h11/8'h22/8'h33 -> writes in order 11,22,33,11 with HOLD_CYCLES=4 giving exactly 4 busy GAP cycles between strobes (plus 1 READ if readback).
REQ-033 HOLD_CYCLES=0, req[0] held -> back-to-back grants every 2 cycles (3 with readback), never two consecutive strobe cycles.
REQ-034 Readback build, PIO model forced to return 8'h00 after write of 8'h5A -> mismatch=1 sticky; mismatch_clr pulse -> mismatch=0.
REQ-035 reset_n low during GAP -> busy=0, strobes idle asynchronously; next req[2] alone after release -> granted with no stale write.
REQ-036 req[0] pulsed high then low while busy -> no ack[0], no write after the current GAP ends.

Source files
------------

// File: rtl/embedded_computer_system_pio_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters onto one Avalon PIO slave,
// with a hold-off gap after each write. Optional readback check: PIO_ARB_READBACK_EN.
module embedded_computer_system_pio_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [1:0]                pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [31:0]               pio_writedata,
  input  logic [31:0]               pio_readdata,
  output logic                      busy,
  output logic [1:0]                grant_id,
  input  logic                      mismatch_clr,
  output logic                      mismatch,
  output logic [1:0]                fsm_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
`ifdef PIO_ARB_READBACK_EN
  localparam logic [1:0] ST_READ  = 2'd2;
`endif
  localparam logic [1:0] ST_GAP   = 2'd3;

  // A zero hold time means a transfer returns straight to IDLE.
  localparam logic [1:0] ST_AFTER_XFER = (HOLD_CYCLES == 0) ? ST_IDLE : ST_GAP;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [7:0]        gap_cnt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sel_data;
  logic [3:0]        req_pad;
  logic [2:0]        cand;
  logic              sel_found;
  logic [1:0]        sel_idx;

  assign req_pad = 4'(req);

  // Search begins one past the last grant so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant_id;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'({1'b0, grant_id}) + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!sel_found && req_pad[cand[1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == 2'(i)) sel_data = wdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (sel_found) state_nx = ST_WRITE;
`ifdef PIO_ARB_READBACK_EN
      ST_WRITE: state_nx = ST_READ;
      ST_READ:  state_nx = ST_AFTER_XFER;
`else
      ST_WRITE: state_nx = ST_AFTER_XFER;
`endif
      ST_GAP:   if (gap_cnt == 8'd0) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      grant_id <= 2'(NUM_REQ - 1);
      gap_cnt  <= '0;
      data_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && sel_found) begin
        grant_id <= sel_idx;
        data_q   <= sel_data;
      end
      if (state_nx == ST_GAP && state != ST_GAP) gap_cnt <= 8'(HOLD_CYCLES - 1);
      else if (state == ST_GAP && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
    end
  end

`ifdef PIO_ARB_READBACK_EN
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^pio_readdata;

  // A fresh error wins over a clear arriving on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mismatch <= 1'b0;
    else if (state == ST_READ && pio_readdata[DATA_W-1:0] != data_q) mismatch <= 1'b1;
    else if (mismatch_clr) mismatch <= 1'b0;
  end

  assign pio_chipselect = (state == ST_WRITE) || (state == ST_READ);
`else
  logic unused_readback;
  assign unused_readback = ^{pio_readdata, mismatch_clr};
  assign mismatch        = 1'b0;
  assign pio_chipselect  = (state == ST_WRITE);
`endif

  assign pio_address   = 2'b00;
  assign pio_write_n   = (state != ST_WRITE);
  assign pio_writedata = (state == ST_WRITE) ? 32'(data_q) : 32'h0;
  assign ack           = (state == ST_WRITE) ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy          = (state != ST_IDLE);
  assign fsm_state     = state;

endmodule

// File: tb/tb_embedded_computer_system_pio_arbiter.sv
// Bench for the PIO arbiter: directed vector table, corner-case sequences and a
// randomized phase checked against a transaction-timing reference model.
module tb_embedded_computer_system_pio_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;
  localparam int HOLD    = 4;
`ifdef PIO_ARB_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  // Edges from one grant to the next sample: WRITE, optional READ, GAP, IDLE.
  localparam int PERIOD = 2 + RB + HOLD;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] wdata;
    logic [2:0]  exp_ack;
    logic [31:0] exp_data;
    logic [1:0]  exp_gid;
  } vec_t;

  logic        clk, reset_n, mismatch_clr, force_zero;
  logic [2:0]  req, ack, req_b, ack_b;
  logic [23:0] wdata, wdata_b;
  logic [1:0]  pio_address, addr_b, grant_id, gid_b, fsm_state, st_b;
  logic        pio_chipselect, pio_write_n, busy, mismatch;
  logic        cs_b, wn_b, busy_b, mm_b;
  logic [31:0] pio_writedata, pio_readdata, wd_b, pio_reg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[7];

  embedded_computer_system_pio_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata), .ack(ack),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .pio_readdata(pio_readdata), .busy(busy),
    .grant_id(grant_id), .mismatch_clr(mismatch_clr), .mismatch(mismatch), .fsm_state(fsm_state)
  );

  embedded_computer_system_pio_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .wdata(wdata_b), .ack(ack_b),
    .pio_address(addr_b), .pio_chipselect(cs_b), .pio_write_n(wn_b),
    .pio_writedata(wd_b), .pio_readdata(wd_b), .busy(busy_b),
    .grant_id(gid_b), .mismatch_clr(mismatch_clr), .mismatch(mm_b), .fsm_state(st_b)
  );

  // Clock / reset and a zero-wait PIO register model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pio_reg <= 32'h0;
    else if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata;
  end
  assign pio_readdata = force_zero ? 32'h0 : pio_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    req_b = '0;
    mismatch_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive_req(input logic [2:0] r, input logic [23:0] d);
    @(negedge clk);
    req = r;
    wdata = d;
  endtask

  initial begin
    int n, stray, cyc, gaps, consec, prev, acks, m_free, m_gid, m_wedge, edge_n, g;
    logic [2:0] last_ack;
    logic [23:0] tmp;
    logic exp_w, found;
    int scyc[$];
    logic [31:0] sdat[$];

    reset_n = 1'b0; req = '0; wdata = '0; req_b = '0; wdata_b = '0;
    mismatch_clr = 1'b0; force_zero = 1'b0;

    vecs[0] = '{3'b010, 24'h00A500, 3'b010, 32'hA5, 2'd1};
    vecs[1] = '{3'b111, 24'h332211, 3'b100, 32'h33, 2'd2};
    vecs[2] = '{3'b011, 24'h00BBAA, 3'b001, 32'hAA, 2'd0};
    vecs[3] = '{3'b110, 24'hDDCC00, 3'b010, 32'hCC, 2'd1};
    vecs[4] = '{3'b101, 24'hF000EE, 3'b100, 32'hF0, 2'd2};
    vecs[5] = '{3'b001, 24'h000077, 3'b001, 32'h77, 2'd0};
    vecs[6] = '{3'b011, 24'h005544, 3'b010, 32'h55, 2'd1};

    #12;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, NUM_REQ - 1);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_cs", pio_chipselect, 0);
    chk("rst_wn", pio_write_n, 1);
    chk("rst_wd", pio_writedata, 0);
    chk("rst_addr", pio_address, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table of isolated transactions walking the round-robin pointer
    foreach (vecs[i]) begin
      drive_req(vecs[i].req, vecs[i].wdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_cs", i), pio_chipselect, 1);
      chk($sformatf("v%0d_wn", i), pio_write_n, 0);
      chk($sformatf("v%0d_data", i), pio_writedata, vecs[i].exp_data);
      chk($sformatf("v%0d_ack", i), ack, vecs[i].exp_ack);
      chk($sformatf("v%0d_gid", i), grant_id, vecs[i].exp_gid);
      chk($sformatf("v%0d_busy", i), busy, 1);
      @(negedge clk);
      req = '0;
      n = 0; stray = 0;
      while (busy && n < 40) begin
        @(posedge clk); #1;
        n++;
        if (ack != 0 || !pio_write_n) stray++;
      end
      chk($sformatf("v%0d_busy_len", i), n, 1 + RB + HOLD);
      chk($sformatf("v%0d_stray", i), stray, 0);
    end

    // All three held: order and spacing of strobes
    do_reset();
    req = 3'b111; wdata = 24'h332211;
    cyc = 0; gaps = 0;
    while (scyc.size() < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (!pio_write_n) begin
        scyc.push_back(cyc);
        sdat.push_back(pio_writedata);
      end else if (busy && !pio_chipselect && scyc.size() > 0) gaps++;
    end
    chk("rr_strobes", scyc.size(), 4);
    if (scyc.size() == 4) begin
      chk("rr_latency", scyc[0], 1);
      chk("rr_d0", sdat[0], 32'h11);
      chk("rr_d1", sdat[1], 32'h22);
      chk("rr_d2", sdat[2], 32'h33);
      chk("rr_d3", sdat[3], 32'h11);
      for (int i = 1; i < 4; i++) chk($sformatf("rr_spacing%0d", i), scyc[i] - scyc[i-1], PERIOD);
      chk("rr_gap_cycles", gaps, 3 * HOLD);
    end
    @(negedge clk);
    req = '0;

    // Zero hold time instance: back-to-back grants, never adjacent strobes
    do_reset();
    req_b = 3'b001; wdata_b = 24'h000042;
    n = 0; consec = 0; prev = -10; acks = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (ack_b[0]) acks++;
      if (!wn_b) begin
        n++;
        if (prev == c - 1) consec++;
        if (prev > 0) chk("h0_spacing", c - prev, 2 + RB);
        chk("h0_data", wd_b, 32'h42);
        prev = c;
      end
    end
    chk("h0_strobes", n, (16 - 1) / (2 + RB) + 1);
    chk("h0_acks", acks, (16 - 1) / (2 + RB) + 1);
    chk("h0_consec", consec, 0);
    @(negedge clk);
    req_b = '0;

    // Request pulsed and withdrawn while busy must vanish
    do_reset();
    req = 3'b010; wdata = 24'h000900;
    @(posedge clk); #1;
    chk("wd_first_ack", ack, 3'b010);
    @(negedge clk); req = '0;
    @(negedge clk); req = 3'b001;
    @(negedge clk); req = '0;
    n = 0; acks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!pio_write_n) n++;
      if (ack[0]) acks++;
    end
    chk("wd_no_write", n, 0);
    chk("wd_no_ack0", acks, 0);

    // Asynchronous reset during GAP
    do_reset();
    req = 3'b001; wdata = 24'h000017;
    @(posedge clk); #1;
    chk("ar_write", pio_writedata, 32'h17);
    @(negedge clk); req = '0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("ar_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_cs", pio_chipselect, 0);
    chk("ar_wn", pio_write_n, 1);
    chk("ar_wd", pio_writedata, 0);
    chk("ar_ack", ack, 0);
    chk("ar_gid", grant_id, NUM_REQ - 1);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (!pio_write_n || ack != 0) n++;
    end
    chk("ar_no_stale", n, 0);
    drive_req(3'b100, 24'hC30000);
    @(posedge clk); #1;
    chk("ar_r2_wn", pio_write_n, 0);
    chk("ar_r2_data", pio_writedata, 32'hC3);
    chk("ar_r2_ack", ack, 3'b100);
    chk("ar_r2_gid", grant_id, 2);
    @(negedge clk); req = '0;

    // Readback against a PIO that loses the write
    do_reset();
    force_zero = 1'b1;
    req = 3'b001; wdata = 24'h00005A;
    @(posedge clk); #1;
    chk("rb_write", pio_writedata, 32'h5A);
    @(negedge clk); req = '0;
`ifdef PIO_ARB_READBACK_EN
    @(posedge clk); #1;
    chk("rb_read_cs", pio_chipselect, 1);
    chk("rb_read_wn", pio_write_n, 1);
    chk("rb_pre_mismatch", mismatch, 0);
    @(posedge clk); #1;
    chk("rb_mismatch_set", mismatch, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rb_mismatch_sticky", mismatch, 1);
    @(negedge clk); mismatch_clr = 1'b1;
    @(negedge clk); mismatch_clr = 1'b0;
    chk("rb_mismatch_clr", mismatch, 0);
`else
    @(posedge clk); #1;
    chk("rb_no_read_cs", pio_chipselect, 0);
    chk("rb_mismatch_tied", mismatch, 0);
    @(negedge clk); mismatch_clr = 1'b1;
    @(negedge clk); mismatch_clr = 1'b0;
    chk("rb_mismatch_clr", mismatch, 0);
`endif
    force_zero = 1'b0;

    // Randomized agents vs. transaction-timing model
    do_reset();
    edge_n = 0; m_free = 1; m_gid = NUM_REQ - 1; m_wedge = -100;
    last_ack = '0;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && last_ack[i]) req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            wdata[i*8 +: 8] = 8'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 40) == 0) req[i] = 1'b0;
      end
      mismatch_clr = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      edge_n++;
      if (edge_n >= m_free) begin
        if (req != 0) begin
          found = 1'b0; g = 0;
          for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(m_gid + k) % NUM_REQ]) begin
              found = 1'b1;
              g = (m_gid + k) % NUM_REQ;
            end
          end
          tmp = wdata >> (8 * g);
          exp_q.push_back(32'(tmp[7:0]));
          m_gid = g;
          m_wedge = edge_n;
          m_free = edge_n + PERIOD;
        end else m_free = edge_n + 1;
      end
      #1;
      exp_w = (m_wedge == edge_n);
      chk("rnd_busy", busy, (edge_n < m_free - 1));
      chk("rnd_cs", pio_chipselect, exp_w || (RB == 1 && edge_n == m_wedge + 1));
      chk("rnd_wn", pio_write_n, !exp_w);
      chk("rnd_ack", ack, exp_w ? (1 << m_gid) : 0);
      chk("rnd_gid", grant_id, m_gid);
      chk("rnd_mismatch", mismatch, 0);
      if (exp_w) chk("rnd_data", pio_writedata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF);
      else chk("rnd_wd_idle", pio_writedata, 0);
      last_ack = ack;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
